// File: rtl/ps2_key_encoder_if.sv
// Signal bundle between the PS/2 pins, the key encoder and the keyboard decoder.
// The encoder uses the master view; the pin driver / consumer side uses the slave view.
interface ps2_key_encoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_error;
    logic        busy;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_error,
        output busy
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_error,
        input  busy
    );
endinterface

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, deserialise frames and
// fold E0/F0/E1 prefixes into the toggle-strobed ps2_key event word.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 32768
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    ps2_key_encoder_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
    localparam int         TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0] line_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [7:0] filt_cnt [2];
    logic       clk_prev;
    logic       fall;
    logic       data_bit;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ext;
    logic             brk;
    logic [2:0]       skip;
    logic [10:0]      key_q;
    logic             frame_error_q;

    assign line_raw = {bus.ps2_data, bus.ps2_clk};

    // NOTE: the synchroniser and filter reset to 1 so that leaving reset on an idle
    // bus does not look like a falling clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            filt        <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
            clk_prev    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let sync2 see last cycle's sync1, forming
            // a real two-stage chain rather than a single flop.
            sync1    <= line_raw;
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign fall     = clk_prev & ~filt[0];
    assign data_bit = filt[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            tmo_cnt       <= '0;
            ext           <= 1'b0;
            brk           <= 1'b0;
            skip          <= '0;
            key_q         <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;

            // The timeout branch is only reachable without a fall event, so it never
            // competes with the frame FSM below.
            if (fall || state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt       <= '0;
                state         <= IDLE;
                frame_error_q <= 1'b1;
                ext           <= 1'b0;
                brk           <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= data_bit;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_bit && (^{shift_reg, parity_bit})) begin
                            if (skip != 3'd0) begin
                                skip <= skip - 3'd1;
                            end else begin
                                case (shift_reg)
                                    8'hE1: skip <= 3'd7;
                                    8'hE0: ext  <= 1'b1;
                                    8'hF0: brk  <= 1'b1;
                                    8'h00, 8'hAA, 8'hEE, 8'hFA,
                                    8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                                        ext <= 1'b0;
                                        brk <= 1'b0;
                                    end
                                    default: begin
                                        key_q <= {~key_q[10], ~brk, ext, shift_reg};
                                        ext   <= 1'b0;
                                        brk   <= 1'b0;
                                    end
                                endcase
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                            ext           <= 1'b0;
                            brk           <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ps2_key     = key_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives PS/2 frames on the pins and checks the
// resulting event words, error pulses, latencies and reset behaviour.
module tb_ps2_key_encoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 20;
    localparam int FALL_LAT   = 2 + FILTER_LEN + 1;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    ps2_key_encoder_if bus ();

    ps2_key_encoder #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_cnt  = 0;
    int   tog_cnt  = 0;
    logic prev_tog = 1'b0;

    always @(negedge clk_sys) begin
        if (bus.frame_error === 1'b1) err_cnt++;
        if (bus.ps2_key[10] !== prev_tog) tog_cnt++;
        prev_tog = bus.ps2_key[10];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b0;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // lat = clk_sys edges from the stop-bit pin fall to the first output reaction.
    task automatic send_frame(input logic [7:0] b, input logic par, output int lat);
        logic [10:0] key0;
        lat = -1;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        bus.ps2_data = 1'b1;
        wait_cycles(HALF);
        key0 = bus.ps2_key;
        bus.ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(posedge clk_sys);
            #1;
            if (lat < 0 && (bus.ps2_key !== key0 || bus.frame_error === 1'b1)) lat = i;
        end
        @(negedge clk_sys);
        bus.ps2_clk = 1'b1;
        wait_cycles(HALF);
    endtask

    initial begin
        int lat;
        int e0;
        int t0;
        logic busy_seen;

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cycles(3);
        check("rst_key",  32'(bus.ps2_key), 32'h0);
        check("rst_err",  32'(bus.frame_error), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset_n = 1'b1;
        wait_cycles(5);

        // Plain make code
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, lat);
        check("make_key",  32'(bus.ps2_key), 32'h61C);
        check("make_lat",  32'(lat), 32'(FALL_LAT));
        check("make_err",  32'(err_cnt - e0), 32'h0);
        check("make_busy", 32'(bus.busy), 32'h0);

        // Break code: F0 1C
        t0 = tog_cnt;
        send_frame(8'hF0, 1'b1, lat);
        check("brk_prefix_no_event", 32'(tog_cnt - t0), 32'h0);
        send_frame(8'h1C, 1'b0, lat);
        check("brk_key",     32'(bus.ps2_key), 32'h01C);
        check("brk_toggles", 32'(tog_cnt - t0), 32'h1);

        // Extended make then extended break
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        check("ext_make_key", 32'(bus.ps2_key), 32'h775);
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hF0, 1'b1, lat);
        send_frame(8'h75, 1'b0, lat);
        check("ext_brk_key", 32'(bus.ps2_key), 32'h175);

        // Parity error also discards a pending F0
        e0 = err_cnt;
        t0 = tog_cnt;
        send_frame(8'hF0, 1'b1, lat);
        send_frame(8'h1C, 1'b1, lat);
        check("par_err_pulse", 32'(err_cnt - e0), 32'h1);
        check("par_err_lat",   32'(lat), 32'(FALL_LAT));
        check("par_key_held",  32'(bus.ps2_key), 32'h175);
        check("par_no_toggle", 32'(tog_cnt - t0), 32'h0);
        send_frame(8'h16, 1'b0, lat);
        check("par_next_key", 32'(bus.ps2_key), 32'h616);

        // Timeout on a partial frame, with a pending E0 that must be dropped
        send_frame(8'hE0, 1'b0, lat);
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b0;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b0;
        lat = -1;
        for (int i = 1; i <= TIMEOUT + 100; i++) begin
            @(posedge clk_sys);
            #1;
            if (i == HALF) bus.ps2_clk = 1'b1;
            if (i == HALF + 20) check("tmo_busy_mid", 32'(bus.busy), 32'h1);
            if (bus.frame_error === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("tmo_lat", 32'(lat), 32'(TIMEOUT + FALL_LAT));
        wait_cycles(2);
        check("tmo_busy", 32'(bus.busy), 32'h0);
        check("tmo_err",  32'(err_cnt - e0), 32'h1);
        send_frame(8'h1C, 1'b0, lat);
        check("tmo_next_key", 32'(bus.ps2_key), 32'h21C);

        // Status byte clears a pending E0
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hAA, 1'b1, lat);
        send_frame(8'h5A, 1'b1, lat);
        check("status_clear_key", 32'(bus.ps2_key), 32'h65A);

        // Short glitch on ps2_clk must be invisible
        e0 = err_cnt;
        busy_seen = 1'b0;
        bus.ps2_clk = 1'b0;
        wait_cycles(3);
        bus.ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        check("glitch_busy", 32'(busy_seen), 32'h0);
        check("glitch_err",  32'(err_cnt - e0), 32'h0);
        check("glitch_key",  32'(bus.ps2_key), 32'h65A);

        // Bad start bit
        e0 = err_cnt;
        ps2_bit(1'b1);
        wait_cycles(HALF);
        check("badstart_err",  32'(err_cnt - e0), 32'h1);
        check("badstart_busy", 32'(bus.busy), 32'h0);

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        check("rstmid_busy_before", 32'(bus.busy), 32'h1);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_key",  32'(bus.ps2_key), 32'h0);
        check("rstmid_err",  32'(bus.frame_error), 32'h0);
        check("rstmid_busy", 32'(bus.busy), 32'h0);
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        t0 = tog_cnt;
        for (int i = 0; i < 6; i++) ps2_bit(1'b1);
        check("rstmid_no_event", 32'(tog_cnt - t0), 32'h0);
        check("rstmid_key_hold", 32'(bus.ps2_key), 32'h0);
        send_frame(8'h1C, 1'b0, lat);
        check("post_rst_key", 32'(bus.ps2_key), 32'h61C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
